// File: rtl/layer_train_sequencer_if.sv
// Shared element type plus the bundled control, sample, layer and result
// signals of layer_train_sequencer.
//   slave  : sequencer view (drives busy/done/s_ready/layer_*/r_*)
//   master : environment view (drives start/s_*/layer_out/r_ready)
package layer_train_pkg;
    typedef logic [7:0] zero2one_t;
endpackage

interface layer_train_sequencer_if #(
    parameter int N       = 16,
    parameter int M       = 55,
    parameter int SAMPLES = 64,
    parameter int EPOCHS  = 8
) ();
    localparam int EW  = $bits(layer_train_pkg::zero2one_t) + $clog2(M + 1);
    localparam int EPW = $clog2(EPOCHS + 1);
    localparam int IXW = $clog2(SAMPLES + 1);

    logic                                   start;
    logic                                   busy;
    logic                                   done;
    logic                                   s_valid;
    logic                                   s_ready;
    layer_train_pkg::zero2one_t [N-1:0]     s_in;
    layer_train_pkg::zero2one_t [M-1:0]     s_expected;
    logic                                   layer_valid;
    logic                                   layer_learn;
    layer_train_pkg::zero2one_t [N-1:0]     layer_in;
    layer_train_pkg::zero2one_t [M-1:0]     layer_expected_out;
    layer_train_pkg::zero2one_t [M-1:0]     layer_out;
    logic                                   r_valid;
    logic                                   r_ready;
    logic [EW-1:0]                          r_error;
    logic [EPW-1:0]                         r_epoch;
    logic [IXW-1:0]                         r_index;

    modport slave (
        input  start, s_valid, s_in, s_expected, layer_out, r_ready,
        output busy, done, s_ready, layer_valid, layer_learn, layer_in,
               layer_expected_out, r_valid, r_error, r_epoch, r_index
    );

    modport master (
        output start, s_valid, s_in, s_expected, layer_out, r_ready,
        input  busy, done, s_ready, layer_valid, layer_learn, layer_in,
               layer_expected_out, r_valid, r_error, r_epoch, r_index
    );
endinterface

// File: rtl/layer_train_sequencer.sv
// Training-run sequencer for one neuron layer (N inputs, M neurons).
// Accepts a sample, pulses the layer's evaluate strobe, waits SETTLE cycles,
// accumulates sum |layer_out[i]-expected[i]| one neuron per cycle, pulses
// learn (except in the final, evaluation-only epoch) and reports the error.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/busy/done control, sample stream (s_*), layer
//                  strobes and operands (layer_*), result stream (r_*)
module layer_train_sequencer #(
    parameter int N       = 16,
    parameter int M       = 55,
    parameter int SETTLE  = 2,
    parameter int SAMPLES = 64,
    parameter int EPOCHS  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    layer_train_sequencer_if.slave bus
);
    import layer_train_pkg::*;

    localparam int ZW   = $bits(zero2one_t);
    localparam int EW   = ZW + $clog2(M + 1);
    localparam int EPW  = $clog2(EPOCHS + 1);
    localparam int IXW  = $clog2(SAMPLES + 1);
    localparam int CMAX = (SETTLE > M) ? SETTLE : M;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_S, ST_EVAL, ST_SETTLE, ST_SCORE, ST_TRAIN, ST_REPORT
    } state_t;

    state_t             state_q;
    logic               busy_q, done_q, s_ready_q, lvalid_q, llearn_q, r_valid_q;
    zero2one_t [N-1:0]  in_q;
    zero2one_t [M-1:0]  exp_q;
    logic [EW-1:0]      acc_q, r_error_q;
    logic [EPW-1:0]     epoch_q, r_epoch_q;
    logic [IXW-1:0]     index_q, r_index_q;
    logic [CW-1:0]      cnt_q;

    zero2one_t          sel_out, sel_exp;
    logic [EW-1:0]      diff;
    logic               last_epoch, last_index;

    // Neuron selected by the score counter; a compare loop keeps the mux
    // legal for any M without a separately sized index.
    always_comb begin
        sel_out = '0;
        sel_exp = '0;
        for (int i = 0; i < M; i++) begin
            if (cnt_q == CW'(i)) begin
                sel_out = bus.layer_out[i];
                sel_exp = exp_q[i];
            end
        end
        diff       = (sel_out > sel_exp) ? EW'(sel_out - sel_exp) : EW'(sel_exp - sel_out);
        last_epoch = (epoch_q == EPW'(EPOCHS - 1));
        last_index = (index_q == IXW'(SAMPLES - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            lvalid_q  <= 1'b0;
            llearn_q  <= 1'b0;
            r_valid_q <= 1'b0;
            in_q      <= '0;
            exp_q     <= '0;
            acc_q     <= '0;
            r_error_q <= '0;
            epoch_q   <= '0;
            r_epoch_q <= '0;
            index_q   <= '0;
            r_index_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_WAIT_S;
                        busy_q    <= 1'b1;
                        s_ready_q <= 1'b1;
                        epoch_q   <= '0;
                        index_q   <= '0;
                    end
                end
                ST_WAIT_S: begin
                    if (bus.s_valid) begin
                        in_q      <= bus.s_in;
                        exp_q     <= bus.s_expected;
                        acc_q     <= '0;
                        s_ready_q <= 1'b0;
                        lvalid_q  <= 1'b1;
                        state_q   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    lvalid_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCORE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SCORE: begin
                    acc_q <= acc_q + diff;
                    if (cnt_q == CW'(M - 1)) begin
                        // Learn strobe is raised on entry so it lines up
                        // with the TRAIN cycle; suppressed in the last epoch.
                        lvalid_q <= !last_epoch;
                        llearn_q <= !last_epoch;
                        state_q  <= ST_TRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_TRAIN: begin
                    lvalid_q  <= 1'b0;
                    llearn_q  <= 1'b0;
                    r_valid_q <= 1'b1;
                    r_error_q <= acc_q;
                    r_epoch_q <= epoch_q;
                    r_index_q <= index_q;
                    state_q   <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (bus.r_ready) begin
                        r_valid_q <= 1'b0;
                        if (!last_index) begin
                            index_q   <= index_q + 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= ST_WAIT_S;
                        end else if (!last_epoch) begin
                            index_q   <= '0;
                            epoch_q   <= epoch_q + 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= ST_WAIT_S;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.s_ready            = s_ready_q;
    assign bus.layer_valid        = lvalid_q;
    assign bus.layer_learn        = llearn_q;
    assign bus.layer_in           = in_q;
    assign bus.layer_expected_out = exp_q;
    assign bus.r_valid            = r_valid_q;
    assign bus.r_error            = r_error_q;
    assign bus.r_epoch            = r_epoch_q;
    assign bus.r_index            = r_index_q;
endmodule

// File: tb/tb_layer_train_sequencer.sv
module tb_layer_train_sequencer;
    import layer_train_pkg::*;

    localparam int N = 4, M = 5, SETTLE = 2, SAMPLES = 3, EPOCHS = 2;
    localparam int LAT = SETTLE + M + 3;   // handshake to r_valid

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_train_sequencer_if #(.N(N), .M(M), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS)) bus ();

    layer_train_sequencer #(
        .N(N), .M(M), .SETTLE(SETTLE), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int learn_cnt = 0;

    always @(posedge clk) if (bus.layer_learn === 1'b1) learn_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference error: plain sum of absolute differences.
    function automatic int ref_err(input zero2one_t [M-1:0] o, input zero2one_t [M-1:0] e);
        int s = 0;
        for (int i = 0; i < M; i++) begin
            int d = int'(o[i]) - int'(e[i]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"},   bus.busy, 0);
        chk({tag, " done"},   bus.done, 0);
        chk({tag, " s_ready"}, bus.s_ready, 0);
        chk({tag, " lvalid"}, bus.layer_valid, 0);
        chk({tag, " llearn"}, bus.layer_learn, 0);
        chk({tag, " r_valid"}, bus.r_valid, 0);
        chk({tag, " r_error"}, bus.r_error, 0);
        chk({tag, " r_epoch"}, bus.r_epoch, 0);
        chk({tag, " r_index"}, bus.r_index, 0);
        chk({tag, " l_in"},   bus.layer_in, 0);
        chk({tag, " l_exp"},  bus.layer_expected_out, 0);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (bus.s_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " s_ready wait"}, bus.s_ready, 1);
    endtask

    // One sample through the sequencer; n selects the stimulus flavour.
    task automatic run_sample(input int e, input int i, input int n);
        zero2one_t [N-1:0] sin;
        zero2one_t [M-1:0] sexp, lout;
        int   err;
        logic learn;
        logic last;
        logic [63:0] held;
        string tg;
        tg = $sformatf("s%0d", n);
        wait_ready(tg);
        for (int j = 0; j < N; j++) sin[j] = 8'($urandom_range(0, 255));
        for (int j = 0; j < M; j++) begin
            sexp[j] = 8'($urandom_range(0, 255));
            lout[j] = 8'($urandom_range(0, 255));
        end
        if (n == 0) lout = sexp;                      // perfect layer
        if (n == 1) begin lout = '0; sexp = '1; end   // worst case
        err   = ref_err(lout, sexp);
        learn = (e < EPOCHS - 1);
        last  = (e == EPOCHS - 1) && (i == SAMPLES - 1);
        bus.s_in       = sin;
        bus.s_expected = sexp;
        bus.layer_out  = lout;
        bus.s_valid    = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk({tg, " layer_in"}, bus.layer_in, 64'(sin));
        chk({tg, " layer_exp"}, bus.layer_expected_out, 64'(sexp));
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) @(negedge clk);
            bus.start = (n == 3 && k == 3);   // start while busy must be ignored
            chk($sformatf("%s k%0d lvalid", tg, k), bus.layer_valid, (k == 1) || (k == LAT - 1 && learn));
            chk($sformatf("%s k%0d llearn", tg, k), bus.layer_learn, (k == LAT - 1) && learn);
            chk($sformatf("%s k%0d r_valid", tg, k), bus.r_valid, k == LAT);
            chk($sformatf("%s k%0d s_ready", tg, k), bus.s_ready, 0);
        end
        bus.start = 1'b0;
        chk({tg, " r_error"}, bus.r_error, err);
        chk({tg, " r_epoch"}, bus.r_epoch, e);
        chk({tg, " r_index"}, bus.r_index, i);
        if (n == 2) begin
            bus.r_ready = 1'b0;
            held = {bus.r_error, bus.r_epoch, bus.r_index};
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk($sformatf("stall%0d r_valid", k), bus.r_valid, 1);
                chk($sformatf("stall%0d result", k), {bus.r_error, bus.r_epoch, bus.r_index}, held);
                chk($sformatf("stall%0d s_ready", k), bus.s_ready, 0);
                chk($sformatf("stall%0d lvalid", k), bus.layer_valid, 0);
            end
            bus.r_ready = 1'b1;
        end
        @(negedge clk);
        chk({tg, " r_valid drop"}, bus.r_valid, 0);
        chk({tg, " done"}, bus.done, last);
        chk({tg, " busy"}, bus.busy, !last);
        chk({tg, " s_ready next"}, bus.s_ready, !last);
    endtask

    initial begin
        int n;
        bus.start      = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_in       = '0;
        bus.s_expected = '0;
        bus.layer_out  = '0;
        bus.r_ready    = 1'b1;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // s_valid in IDLE must not be accepted.
        bus.s_valid = 1'b1;
        bus.s_in    = 32'hA5A5_5A5A;
        repeat (3) begin
            @(negedge clk);
            chk("idle s_ready", bus.s_ready, 0);
            chk("idle busy", bus.busy, 0);
            chk("idle layer_in", bus.layer_in, 0);
        end
        bus.s_valid = 1'b0;

        // Full run: EPOCHS x SAMPLES samples.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start busy", bus.busy, 1);
        n = 0;
        for (int e = 0; e < EPOCHS; e++)
            for (int i = 0; i < SAMPLES; i++) begin
                run_sample(e, i, n);
                n++;
            end
        @(negedge clk);
        chk("done width", bus.done, 0);
        chk("learn pulses", learn_cnt, SAMPLES * (EPOCHS - 1));

        // Reset in the middle of SCORE.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready("rst");
        bus.s_in       = 32'h1122_3344;
        bus.s_expected = '1;
        bus.layer_out  = '0;
        bus.s_valid    = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (SETTLE + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        for (int k = 0; k < SETTLE + M + 4; k++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d llearn", k), bus.layer_learn, 0);
            chk($sformatf("postrst%0d lvalid", k), bus.layer_valid, 0);
            chk($sformatf("postrst%0d busy", k), bus.busy, 0);
        end
        chk("learn after reset", learn_cnt, SAMPLES * (EPOCHS - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
